// File: rtl/exp_sig_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exp_sig_test_sequencer
// Description : Sweeps the exp_sig_gen delay code and reports the signed peak
//               of the filter output for each point.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_sig_test_sequencer #(
   parameter int SIZE_DELAY       = 8,
   parameter int SIZE_FILTER_DATA = 16,
   parameter int SETTLE_CYCLES    = 64,
   parameter int WINDOW_CYCLES    = 256,
   parameter int SIZE_INDEX       = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   input  logic [SIZE_DELAY-1:0]       cfg_delay_first,
   input  logic [SIZE_DELAY-1:0]       cfg_delay_last,
   input  logic [SIZE_DELAY-1:0]       cfg_delay_step,
   input  logic                        cfg_overlay,
   input  logic                        cfg_rate,
   input  logic [SIZE_FILTER_DATA-1:0] filter_data,
   output logic                        test_overlay,
   output logic                        test_rate,
   output logic [SIZE_DELAY-1:0]       test_delay,
   output logic                        busy,
   output logic                        result_valid,
   output logic [SIZE_INDEX-1:0]       result_index,
   output logic [SIZE_DELAY-1:0]       result_delay,
   output logic [SIZE_FILTER_DATA-1:0] result_peak,
   output logic                        done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      MEASURE = 3'd2,
      REPORT  = 3'd3,
      NEXT    = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam int c_cnt_max = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
   localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_window_last = c_cnt_w'(WINDOW_CYCLES - 1);
   localparam logic [SIZE_FILTER_DATA-1:0] c_peak_min = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

   state_t                        r_state;
   state_t                        w_state_next;
   logic [c_cnt_w-1:0]            r_cnt;
   logic [SIZE_DELAY-1:0]         r_last;
   logic [SIZE_DELAY-1:0]         r_step;
   logic [SIZE_INDEX-1:0]         r_index;
   logic [SIZE_FILTER_DATA-1:0]   r_peak;
   logic [SIZE_DELAY:0]           w_sum;
   logic                          w_sweep_end;
   logic [SIZE_FILTER_DATA-1:0]   w_peak_max;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      // Extra bit on the sum catches delay-code overflow before it is driven.
      w_sum        = {1'b0, test_delay} + {1'b0, r_step};
      w_sweep_end  = (r_step == '0) || (w_sum > {1'b0, r_last}) || (test_delay >= r_last);
      w_peak_max   = ($signed(filter_data) > $signed(r_peak)) ? filter_data : r_peak;
      case (r_state)
         IDLE:    if (start) w_state_next = SETTLE;
         SETTLE:  if (r_cnt == c_settle_last) w_state_next = MEASURE;
         MEASURE: if (r_cnt == c_window_last) w_state_next = REPORT;
         REPORT:  w_state_next = NEXT;
         NEXT:    w_state_next = w_sweep_end ? DONE : SETTLE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if ((r_state != IDLE) && abort) w_state_next = IDLE;
   end

   // Outputs are registered from the next state so pulses line up with the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         test_overlay <= 1'b0;
         test_rate    <= 1'b0;
         test_delay   <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result_index <= '0;
         result_delay <= '0;
         result_peak  <= '0;
         done         <= 1'b0;
         r_cnt        <= '0;
         r_last       <= '0;
         r_step       <= '0;
         r_index      <= '0;
         r_peak       <= '0;
      end else begin
         busy         <= (w_state_next != IDLE);
         result_valid <= (w_state_next == REPORT);
         done         <= (w_state_next == DONE);
         case (r_state)
            IDLE: begin
               if (start) begin
                  test_overlay <= cfg_overlay;
                  test_rate    <= cfg_rate;
                  test_delay   <= cfg_delay_first;
                  r_last       <= cfg_delay_last;
                  r_step       <= cfg_delay_step;
                  r_index      <= '0;
                  r_cnt        <= '0;
               end
            end
            SETTLE: begin
               if (r_cnt == c_settle_last) begin
                  r_cnt  <= '0;
                  r_peak <= c_peak_min;
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            MEASURE: begin
               r_peak <= w_peak_max;
               if (r_cnt == c_window_last) r_cnt <= '0;
               else                        r_cnt <= r_cnt + c_cnt_w'(1);
               if (w_state_next == REPORT) begin
                  result_peak  <= w_peak_max;
                  result_delay <= test_delay;
                  result_index <= r_index;
               end
            end
            NEXT: begin
               if (w_state_next == SETTLE) begin
                  test_delay <= w_sum[SIZE_DELAY-1:0];
                  r_index    <= r_index + SIZE_INDEX'(1);
               end
            end
            default: ;
         endcase
         if (w_state_next == IDLE) begin
            test_overlay <= 1'b0;
            test_rate    <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exp_sig_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_sig_test_sequencer
// Description : Self-checking bench for exp_sig_test_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_sig_test_sequencer;

   localparam int S = 4;
   localparam int W = 8;
   localparam int P = S + W + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [7:0]  cfg_delay_first;
   logic [7:0]  cfg_delay_last;
   logic [7:0]  cfg_delay_step;
   logic        cfg_overlay;
   logic        cfg_rate;
   logic [15:0] filter_data;
   logic        test_overlay;
   logic        test_rate;
   logic [7:0]  test_delay;
   logic        busy;
   logic        result_valid;
   logic [7:0]  result_index;
   logic [7:0]  result_delay;
   logic [15:0] result_peak;
   logic        done;

   int errors = 0;
   int checks = 0;
   logic [15:0] samp [0:4095];

   always #5 clk = ~clk;

   exp_sig_test_sequencer #(
      .SIZE_DELAY(8), .SIZE_FILTER_DATA(16), .SETTLE_CYCLES(S),
      .WINDOW_CYCLES(W), .SIZE_INDEX(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_delay_first(cfg_delay_first), .cfg_delay_last(cfg_delay_last),
      .cfg_delay_step(cfg_delay_step), .cfg_overlay(cfg_overlay), .cfg_rate(cfg_rate),
      .filter_data(filter_data), .test_overlay(test_overlay), .test_rate(test_rate),
      .test_delay(test_delay), .busy(busy), .result_valid(result_valid),
      .result_index(result_index), .result_delay(result_delay),
      .result_peak(result_peak), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"}, {31'b0, busy}, 0);
      check({tag, ".valid"}, {31'b0, result_valid}, 0);
      check({tag, ".done"}, {31'b0, done}, 0);
      check({tag, ".overlay"}, {31'b0, test_overlay}, 0);
      check({tag, ".rate"}, {31'b0, test_rate}, 0);
      check({tag, ".delay"}, {24'b0, test_delay}, 0);
      check({tag, ".r_index"}, {24'b0, result_index}, 0);
      check({tag, ".r_delay"}, {24'b0, result_delay}, 0);
      check({tag, ".r_peak"}, {16'b0, result_peak}, 0);
   endtask

   // mode 0: ramp, 1: constant -5, 2: random, 3: -5 with a single +100 pulse
   function automatic logic [15:0] gen(input int mode, input int c, input int pulse_c);
      case (mode)
         0:       return 16'(c);
         1:       return 16'hFFFB;
         2:       return 16'($urandom);
         default: return (c == pulse_c) ? 16'd100 : 16'hFFFB;
      endcase
   endfunction

   task automatic run_sweep(input int first, input int last, input int step,
                            input logic ov, input logic rt, input int mode,
                            input int pulse_c, input int abort_c, input int start_c);
      logic [7:0] pts [$];
      int d, n, lim, total, eff, k, kk, pk;
      logic live, exp_valid;
      pts.delete();
      d = first;
      while (1) begin
         pts.push_back(8'(d));
         if (step == 0 || d >= last || d + step > last) break;
         d += step;
      end
      n     = pts.size();
      lim   = n * P + 1;
      total = (abort_c > 0) ? abort_c + 4 : lim + 2;

      @(posedge clk); #1;
      cfg_delay_first = 8'(first);
      cfg_delay_last  = 8'(last);
      cfg_delay_step  = 8'(step);
      cfg_overlay     = ov;
      cfg_rate        = rt;
      start           = 1'b1;
      abort           = 1'b0;
      @(posedge clk); #1;
      start           = 1'b0;
      cfg_delay_first = 8'($urandom);
      cfg_delay_last  = 8'($urandom);
      cfg_delay_step  = 8'($urandom);
      cfg_overlay     = ~ov;
      cfg_rate        = ~rt;
      for (int c = 1; c <= total; c++) begin
         filter_data = gen(mode, c, pulse_c);
         samp[c]     = filter_data;
         start       = (c == start_c);
         abort       = (c == abort_c);
         @(negedge clk);
         eff  = (abort_c > 0 && c > abort_c) ? abort_c : c;
         live = (c <= lim) && (abort_c == 0 || c <= abort_c);
         k    = (eff - 1) / P;
         if (k > n - 1) k = n - 1;
         exp_valid = live && ((c - 1) % P == S + W) && ((c - 1) / P < n);
         check("busy", {31'b0, busy}, {31'b0, live});
         check("test_delay", {24'b0, test_delay}, {24'b0, pts[k]});
         check("test_overlay", {31'b0, test_overlay}, {31'b0, live ? ov : 1'b0});
         check("test_rate", {31'b0, test_rate}, {31'b0, live ? rt : 1'b0});
         check("result_valid", {31'b0, result_valid}, {31'b0, exp_valid});
         check("done", {31'b0, done}, {31'b0, live && (c == lim)});
         if (exp_valid) begin
            kk = (c - 1) / P;
            pk = -32768;
            for (int j = kk * P + S + 1; j <= kk * P + S + W; j++)
               if (int'($signed(samp[j])) > pk) pk = int'($signed(samp[j]));
            check("result_index", {24'b0, result_index}, 32'(kk % 256));
            check("result_delay", {24'b0, result_delay}, {24'b0, pts[kk]});
            check("result_peak", {16'b0, result_peak}, {16'b0, 16'(pk)});
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_delay_first = '0; cfg_delay_last = '0; cfg_delay_step = '0;
      cfg_overlay = 1'b0; cfg_rate = 1'b0; filter_data = '0;
      #12;
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      run_sweep(10, 20, 5, 1'b1, 1'b1, 0, 0, 0, 0);       // ramp, 3 points
      run_sweep(7, 200, 0, 1'b1, 1'b0, 2, 0, 0, 0);       // step 0
      run_sweep(30, 20, 5, 1'b0, 1'b1, 2, 0, 0, 0);       // first > last
      run_sweep(250, 255, 4, 1'b1, 1'b1, 2, 0, 0, 0);     // near wrap
      run_sweep(10, 40, 3, 1'b1, 1'b0, 1, 0, 0, 0);       // constant -5
      run_sweep(0, 0, 1, 1'b0, 1'b0, 3, S + 3, 0, 0);     // pulse in window
      run_sweep(0, 0, 1, 1'b0, 1'b0, 3, 2, 0, 0);         // pulse in settle
      run_sweep(10, 50, 10, 1'b1, 1'b1, 2, 0, P + S + 3, 0); // abort in point 1
      run_sweep(5, 15, 5, 1'b1, 1'b1, 0, 0, 0, 0);        // re-run after abort
      run_sweep(1, 9, 4, 1'b1, 1'b1, 2, 0, 0, P + 2);     // start while busy

      // Asynchronous reset in the middle of SETTLE
      @(posedge clk); #1;
      cfg_delay_first = 8'd33; cfg_delay_last = 8'd99; cfg_delay_step = 8'd3;
      cfg_overlay = 1'b1; cfg_rate = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(posedge clk); #1;
      reset = 1'b0;

      for (int r = 0; r < 4; r++)
         run_sweep($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 9),
                   1'($urandom), 1'($urandom), 2, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
